// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size codes, FSM encoding and legality helper for the MEM-stage access unit
package mem_access_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int CNT_W_DEFAULT          = 8;

    // Access attributes kept after IDLE; the pipeline inputs are not looked at again.
    typedef struct packed {
        logic       we;
        logic [2:0] size;
        logic [1:0] offset;
    } acc_ctl_t;

    function automatic logic access_legal(input logic is_store,
                                          input logic [2:0] size,
                                          input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~offset[0];
            SZ_W:        ok = (offset == 2'b00);
            default:     ok = 1'b0;
        endcase
        // Unsigned variants only make sense for loads.
        if (is_store && size[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/response bus between the access unit and memory
interface mem_access_unit_if;

    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_GNT;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;

    modport master (
        output MEM_REQ,
        output MEM_WE,
        output MEM_ADDR,
        output MEM_WSTRB,
        output MEM_WDATA,
        input  MEM_GNT,
        input  MEM_RVALID,
        input  MEM_RDATA
    );

    modport slave (
        input  MEM_REQ,
        input  MEM_WE,
        input  MEM_ADDR,
        input  MEM_WSTRB,
        input  MEM_WDATA,
        output MEM_GNT,
        output MEM_RVALID,
        output MEM_RDATA
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - selects the addressed byte/half lane of read data and extends it
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        // Halves are always aligned, so only offset bit 1 picks the lane.
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_B:    result_o = {{24{byte_lane[7]}}, byte_lane};
            SZ_BU:   result_o = {24'd0, byte_lane};
            SZ_H:    result_o = {{16{half_lane[15]}}, half_lane};
            SZ_HU:   result_o = {16'd0, half_lane};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage unit turning EX/MEM access requests into handshaked bus cycles
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                IN_DATAMEMSEL,
    input  logic [3:0]          IN_READ_WRITE,
    input  logic [31:0]         IN_ADDR,
    input  logic [31:0]         IN_STORE_DATA,
    mem_access_unit_if.master   bus,
    output logic [31:0]         OUT_LOAD_DATA,
    output logic                OUT_LOAD_VALID,
    output logic                OUT_STALL,
    output logic                OUT_MISALIGNED,
    output logic                OUT_BUS_ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_ctl_t         ctl_q, ctl_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      ldata_q, ldata_d;
    logic             lvalid_q, lvalid_d;
    logic             berr_q, berr_d;

    logic             in_store;
    logic [2:0]       in_size;
    logic             in_legal;
    logic             acc_ok;
    logic [3:0]       st_strb;
    logic [31:0]      st_wdata;
    logic [31:0]      aligned_rdata;
    logic             timeout_hit;

    assign in_store    = IN_READ_WRITE[3];
    assign in_size     = IN_READ_WRITE[2:0];
    assign in_legal    = access_legal(in_store, in_size, IN_ADDR[1:0]);
    assign acc_ok      = IN_DATAMEMSEL & in_legal;
    assign timeout_hit = (cnt_q >= CNT_LAST);

    // Lane replication lets memory take the write data straight off the strobed lanes.
    always_comb begin
        case (in_size[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << IN_ADDR[1:0];
                st_wdata = {4{IN_STORE_DATA[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << IN_ADDR[1:0];
                st_wdata = {2{IN_STORE_DATA[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = IN_STORE_DATA;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i  (bus.MEM_RDATA),
        .offset_i (ctl_q.offset),
        .size_i   (ctl_q.size),
        .result_o (aligned_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctl_d    = ctl_q;
        req_d    = req_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        lvalid_d = 1'b0;
        berr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc_ok) begin
                    state_d      = S_REQ;
                    cnt_d        = '0;
                    ctl_d.we     = in_store;
                    ctl_d.size   = in_size;
                    ctl_d.offset = IN_ADDR[1:0];
                    req_d        = 1'b1;
                    addr_d       = {IN_ADDR[31:2], 2'b00};
                    wstrb_d      = st_strb;
                    wdata_d      = st_wdata;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A grant on the last budget cycle still wins over the timeout.
                if (bus.MEM_GNT) begin
                    req_d   = 1'b0;
                    state_d = ctl_q.we ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    ldata_d = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.MEM_RVALID) begin
                    state_d  = S_DONE;
                    ldata_d  = aligned_rdata;
                    lvalid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    ldata_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ctl_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctl_q    <= ctl_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            berr_q   <= berr_d;
        end
    end

    assign bus.MEM_REQ    = req_q;
    assign bus.MEM_WE     = ctl_q.we;
    assign bus.MEM_ADDR   = addr_q;
    assign bus.MEM_WSTRB  = wstrb_q;
    assign bus.MEM_WDATA  = wdata_q;

    assign OUT_LOAD_DATA  = ldata_q;
    assign OUT_LOAD_VALID = lvalid_q;
    assign OUT_BUS_ERR    = berr_q;
    assign OUT_STALL      = ((state_q == S_IDLE) && acc_ok) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign OUT_MISALIGNED = (state_q == S_IDLE) && IN_DATAMEMSEL && !in_legal;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_DATAMEMSEL;
    logic [3:0]  IN_READ_WRITE;
    logic [31:0] IN_ADDR;
    logic [31:0] IN_STORE_DATA;
    logic [31:0] OUT_LOAD_DATA;
    logic        OUT_LOAD_VALID;
    logic        OUT_STALL;
    logic        OUT_MISALIGNED;
    logic        OUT_BUS_ERR;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .IN_DATAMEMSEL  (IN_DATAMEMSEL),
        .IN_READ_WRITE  (IN_READ_WRITE),
        .IN_ADDR        (IN_ADDR),
        .IN_STORE_DATA  (IN_STORE_DATA),
        .bus            (bus),
        .OUT_LOAD_DATA  (OUT_LOAD_DATA),
        .OUT_LOAD_VALID (OUT_LOAD_VALID),
        .OUT_STALL      (OUT_STALL),
        .OUT_MISALIGNED (OUT_MISALIGNED),
        .OUT_BUS_ERR    (OUT_BUS_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          stall_cyc, req_cyc, lv_cyc, berr_cyc, mis_cyc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ldata;
        logic        hung;
    } obs_t;

    // Reference rules written from the access definitions, not from the RTL structure.
    function automatic logic m_legal(input logic st, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'd3 || sz >= 3'd6) return 1'b0;
        if (st && sz >= 3'd4) return 1'b0;
        if ((sz == 3'd1 || sz == 3'd5) && (a % 2 != 0)) return 1'b0;
        if (sz == 3'd2 && (a % 4 != 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] sh;
        sh = rd >> (8 * (a % 4));
        case (sz)
            3'd0:    return sh[7]  ? ((sh & 32'hFF)   | 32'hFFFFFF00) : (sh & 32'hFF);
            3'd1:    return sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
            3'd4:    return sh & 32'hFF;
            3'd5:    return sh & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'd0) return 4'(1 << (a % 4));
        if (sz == 3'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
        if (sz == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Presents one access and plays the memory side, recording what the unit did.
    task automatic run_access(input logic st, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int gd, input int rdl, output obs_t o);
        int   rk, wk, tail;
        logic granted, done;
        o.stall_cyc = 0; o.req_cyc = 0; o.lv_cyc = 0; o.berr_cyc = 0; o.mis_cyc = 0;
        o.we = 1'b0; o.addr = '0; o.wstrb = '0; o.wdata = '0; o.ldata = '0; o.hung = 1'b0;
        rk = 0; wk = 0; tail = 0; granted = 1'b0; done = 1'b0;
        @(negedge CLK);
        IN_DATAMEMSEL = 1'b1; IN_READ_WRITE = {st, sz}; IN_ADDR = a; IN_STORE_DATA = wd;
        bus.MEM_GNT = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = rd;
        for (int c = 0; c < 40 && tail < 3; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                bus.MEM_GNT = 1'b0; bus.MEM_RVALID = 1'b0;
                if (bus.MEM_REQ) begin
                    if (rk == gd) begin bus.MEM_GNT = 1'b1; granted = 1'b1; end
                    rk++;
                end else if (granted && !st) begin
                    bus.MEM_RVALID = (wk == rdl);
                    wk++;
                end
            end
            #1;
            if (OUT_STALL) o.stall_cyc++;
            if (OUT_MISALIGNED) o.mis_cyc++;
            if (bus.MEM_REQ) begin
                if (o.req_cyc == 0) begin
                    o.we = bus.MEM_WE; o.addr = bus.MEM_ADDR; o.wstrb = bus.MEM_WSTRB; o.wdata = bus.MEM_WDATA;
                end
                o.req_cyc++;
            end
            if (OUT_LOAD_VALID) begin o.lv_cyc++; o.ldata = OUT_LOAD_DATA; end
            if (OUT_BUS_ERR) begin o.berr_cyc++; o.ldata = OUT_LOAD_DATA; end
            if (!OUT_STALL) begin IN_DATAMEMSEL = 1'b0; done = 1'b1; end
            if (done) tail++;
        end
        if (tail < 3) o.hung = 1'b1;
        bus.MEM_GNT = 1'b0; bus.MEM_RVALID = 1'b0; IN_DATAMEMSEL = 1'b0;
    endtask

    task automatic test_reset();
        logic [105:0] snap;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        snap = {bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WSTRB, bus.MEM_WDATA,
                OUT_LOAD_DATA, OUT_LOAD_VALID, OUT_BUS_ERR, OUT_STALL, OUT_MISALIGNED};
        checks++; if (snap !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", snap); end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_store();
        obs_t o;
        run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, o);
        checks++; if (o.req_cyc !== 1) begin errors++; $display("FAIL sw_req_cycles got %0d exp 1", o.req_cyc); end
        checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 00000100", o.addr); end
        checks++; if (o.wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got %b exp 1111", o.wstrb); end
        checks++; if (o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", o.wdata); end
        checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", o.we); end
        checks++; if (o.stall_cyc !== 2) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 2", o.stall_cyc); end
        checks++; if (o.lv_cyc !== 0) begin errors++; $display("FAIL sw_load_valid got %0d exp 0", o.lv_cyc); end
        run_access(1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0, 0, 0, o);
        checks++; if (o.wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b exp 0010", o.wstrb); end
        checks++; if (o.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o.wdata); end
        checks++; if (o.stall_cyc !== 2) begin errors++; $display("FAIL sb_stall_cycles got %0d exp 2", o.stall_cyc); end
    endtask

    task automatic test_load();
        obs_t o;
        run_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 2, 0, o);
        checks++; if (o.ldata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", o.ldata); end
        checks++; if (o.lv_cyc !== 1) begin errors++; $display("FAIL lb_valid_cycles got %0d exp 1", o.lv_cyc); end
        checks++; if (o.stall_cyc !== 5) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 5", o.stall_cyc); end
        checks++; if (o.req_cyc !== 3) begin errors++; $display("FAIL lb_req_cycles got %0d exp 3", o.req_cyc); end
        checks++; if (o.we !== 1'b0 || o.addr !== 32'h100) begin errors++; $display("FAIL lb_bus we %b addr %h exp 0 00000100", o.we, o.addr); end
        run_access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80123456, 0, 0, o);
        checks++; if (o.ldata !== 32'h00008012) begin errors++; $display("FAIL lhu_data got %h exp 00008012", o.ldata); end
        checks++; if (o.stall_cyc !== 3) begin errors++; $display("FAIL lhu_stall_cycles got %0d exp 3", o.stall_cyc); end
    endtask

    task automatic test_reset_in_wait();
        logic [105:0] snap;
        @(negedge CLK);
        IN_DATAMEMSEL = 1'b1; IN_READ_WRITE = 4'b0010; IN_ADDR = 32'h200; IN_STORE_DATA = 32'h0;
        bus.MEM_GNT = 1'b1; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = 32'hCAFEF00D;
        @(negedge CLK);
        @(negedge CLK);
        bus.MEM_GNT = 1'b0;
        #1;
        checks++; if (OUT_STALL !== 1'b1 || bus.MEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_wait_entry stall %b req %b exp 1 0", OUT_STALL, bus.MEM_REQ); end
        #2 RST_N = 1'b0; IN_DATAMEMSEL = 1'b0;
        #1;
        snap = {bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WSTRB, bus.MEM_WDATA,
                OUT_LOAD_DATA, OUT_LOAD_VALID, OUT_BUS_ERR, OUT_STALL, OUT_MISALIGNED};
        checks++; if (snap !== '0) begin errors++; $display("FAIL rst_wait_async got %h exp 0", snap); end
        @(negedge CLK);
        RST_N = 1'b1; bus.MEM_RVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            snap = {bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WSTRB, bus.MEM_WDATA,
                    OUT_LOAD_DATA, OUT_LOAD_VALID, OUT_BUS_ERR, OUT_STALL, OUT_MISALIGNED};
            checks++; if (snap !== '0) begin errors++; $display("FAIL rst_rvalid_ignored cycle %0d got %h exp 0", i, snap); end
        end
        bus.MEM_RVALID = 1'b0;
    endtask

    task automatic test_illegal();
        obs_t o;
        run_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, o);
        checks++; if (o.mis_cyc !== 1) begin errors++; $display("FAIL lw_mis_cycles got %0d exp 1", o.mis_cyc); end
        checks++; if (o.req_cyc !== 0 || o.stall_cyc !== 0) begin errors++; $display("FAIL lw_mis_bus req %0d stall %0d exp 0 0", o.req_cyc, o.stall_cyc); end
        run_access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, o);
        checks++; if (o.mis_cyc !== 1) begin errors++; $display("FAIL code3_mis_cycles got %0d exp 1", o.mis_cyc); end
        checks++; if (o.req_cyc !== 0 || o.stall_cyc !== 0) begin errors++; $display("FAIL code3_bus req %0d stall %0d exp 0 0", o.req_cyc, o.stall_cyc); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 3'd2, 32'h104, 32'h0, 32'h12345678, 0, 50, o);
        checks++; if (o.berr_cyc !== 1) begin errors++; $display("FAIL to_berr_cycles got %0d exp 1", o.berr_cyc); end
        checks++; if (o.lv_cyc !== 0) begin errors++; $display("FAIL to_load_valid got %0d exp 0", o.lv_cyc); end
        checks++; if (o.ldata !== 32'h0) begin errors++; $display("FAIL to_load_data got %h exp 0", o.ldata); end
        checks++; if (o.stall_cyc !== 1 + T) begin errors++; $display("FAIL to_stall_cycles got %0d exp %0d", o.stall_cyc, 1 + T); end
        run_access(1'b1, 3'd2, 32'h108, 32'h11223344, 32'h0, 10, 0, o);
        checks++; if (o.req_cyc !== T || o.berr_cyc !== 1) begin errors++; $display("FAIL to_req_abort req %0d berr %0d exp %0d 1", o.req_cyc, o.berr_cyc, T); end
        run_access(1'b1, 3'd2, 32'h10C, 32'h55667788, 32'h0, 0, 0, o);
        checks++; if (o.berr_cyc !== 0 || o.stall_cyc !== 2) begin errors++; $display("FAIL to_recover berr %0d stall %0d exp 0 2", o.berr_cyc, o.stall_cyc); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        st, lg, ld, ab, abq;
        logic [2:0]  sz;
        logic [31:0] a, wd, rd;
        int          gd, rdl, es, er;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom; rd = $urandom;
            gd = $urandom_range(0, 4); rdl = $urandom_range(0, 2);
            if (!st && gd == T - 1) gd = T;
            run_access(st, sz, a, wd, rd, gd, rdl, o);
            lg  = m_legal(st, sz, a);
            ld  = lg && !st;
            abq = lg && (gd >= T);
            ab  = abq || (ld && (gd + rdl + 2 > T));
            es  = !lg ? 0 : (ab ? 1 + T : 1 + gd + 1 + (ld ? rdl + 1 : 0));
            er  = !lg ? 0 : (abq ? T : gd + 1);
            checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL rnd%0d completion got hung exp done", i); end
            checks++; if (o.stall_cyc !== es) begin errors++; $display("FAIL rnd%0d stall_cycles got %0d exp %0d", i, o.stall_cyc, es); end
            checks++; if (o.req_cyc !== er) begin errors++; $display("FAIL rnd%0d req_cycles got %0d exp %0d", i, o.req_cyc, er); end
            checks++; if (o.mis_cyc !== (lg ? 0 : 1)) begin errors++; $display("FAIL rnd%0d mis_cycles got %0d exp %0d", i, o.mis_cyc, lg ? 0 : 1); end
            checks++; if (o.berr_cyc !== (ab ? 1 : 0)) begin errors++; $display("FAIL rnd%0d berr_cycles got %0d exp %0d", i, o.berr_cyc, ab ? 1 : 0); end
            checks++; if (o.lv_cyc !== ((ld && !ab) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d lv_cycles got %0d exp %0d", i, o.lv_cyc, (ld && !ab) ? 1 : 0); end
            if (ld || ab) begin
                checks++; if (o.ldata !== (ab ? 32'h0 : m_load(rd, sz, a))) begin errors++; $display("FAIL rnd%0d load_data got %h exp %h", i, o.ldata, ab ? 32'h0 : m_load(rd, sz, a)); end
            end
            if (lg) begin
                checks++; if (o.addr !== (a & 32'hFFFFFFFC) || o.we !== st) begin errors++; $display("FAIL rnd%0d bus addr %h we %b exp %h %b", i, o.addr, o.we, a & 32'hFFFFFFFC, st); end
            end
            if (lg && st) begin
                checks++; if (o.wstrb !== m_strb(sz, a)) begin errors++; $display("FAIL rnd%0d wstrb got %b exp %b", i, o.wstrb, m_strb(sz, a)); end
                checks++; if (o.wdata !== m_wdata(sz, wd)) begin errors++; $display("FAIL rnd%0d wdata got %h exp %h", i, o.wdata, m_wdata(sz, wd)); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog still running at %0t exp finished", $time);
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; IN_DATAMEMSEL = 1'b0; IN_READ_WRITE = '0; IN_ADDR = '0; IN_STORE_DATA = '0;
        bus.MEM_GNT = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = '0;
        test_reset();
        test_store();
        test_load();
        test_reset_in_wait();
        test_illegal();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It turns the registered access request (address = ALU result, store data = DATA2, READ_WRITE code, DATAMEMSEL) into a handshaked data-memory bus transaction. It aligns and sign- or zero-extends load data for the MEM/WB register. It stalls the pipeline until the transaction completes, and flags misaligned accesses, illegal codes and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited in REQ plus WAIT before the access is aborted with a bus error; must be at least 1
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
IN_DATAMEMSEL  in  1  1 = a memory access is present this cycle
IN_READ_WRITE  in  4  [3] = store(1) / load(0); [2:0] = size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
IN_ADDR  in  32  byte address (EX/MEM ALU result)
IN_STORE_DATA  in  32  store data (EX/MEM DATA2)
MEM_REQ  out  1  bus request
MEM_WE  out  1  1 = write
MEM_ADDR  out  32  word-aligned address, {IN_ADDR[31:2],2'b00}
MEM_WSTRB  out  4  byte enables
MEM_WDATA  out  32  lane-replicated store data
MEM_GNT  in  1  request accepted
MEM_RVALID  in  1  read data valid
MEM_RDATA  in  32  read data
OUT_LOAD_DATA  out  32  extended load result
OUT_LOAD_VALID  out  1  OUT_LOAD_DATA valid this cycle
OUT_STALL  out  1  freeze IF/ID/EX and the EX/MEM register
OUT_MISALIGNED  out  1  misaligned or illegal-code access, no bus cycle issued
OUT_BUS_ERR  out  1  access aborted on timeout

Behaviour:
- Reset (asynchronous):
  - state goes to IDLE; counter cleared.
  - All registered outputs are 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA, OUT_LOAD_DATA, OUT_LOAD_VALID, OUT_BUS_ERR.
  - No X values anywhere.
  - Reset in any state aborts the access; no completion is reported.
- Access legality:
  - Legal: IN_DATAMEMSEL=1, size code legal, and aligned. H/HU need ADDR[0]=0; W needs ADDR[1:0]=00.
  - Size codes 011, 110 and 111, and store with code 1xx, are illegal.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Legal access: OUT_STALL=1 (combinational, same cycle). Latch MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA, load size/sign and ADDR[1:0]. Next state REQ.
  - Illegal access: OUT_MISALIGNED=1 (combinational, that cycle only), OUT_STALL=0, no bus activity, stay in IDLE.
  - IN_DATAMEMSEL=0: nothing happens.
- REQ:
  - MEM_REQ=1 and OUT_STALL=1; bus fields stay stable until MEM_GNT.
  - On MEM_GNT: a store goes to DONE; a load goes to WAIT. MEM_REQ drops on that same edge.
  - MEM_RVALID in the same cycle as MEM_GNT is not accepted; the load still goes to WAIT.
- WAIT:
  - OUT_STALL=1.
  - On MEM_RVALID: register the extended MEM_RDATA into OUT_LOAD_DATA; next state DONE.
- DONE (one cycle):
  - OUT_STALL=0.
  - OUT_LOAD_VALID=1 for loads.
  - OUT_BUS_ERR=1 if the access was aborted.
  - Next state IDLE. The pipeline advances on this edge.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion: MEM_REQ=0, go to DONE with OUT_BUS_ERR=1, OUT_LOAD_DATA=0, OUT_LOAD_VALID=0.
- MEM_RVALID seen in IDLE, REQ or DONE is ignored.
- Stores:
  - B: WSTRB = 0001 << ADDR[1:0]; WDATA = byte replicated ×4.
  - H: WSTRB = 0011 << ADDR[1:0]; WDATA = half replicated ×2.
  - W: WSTRB = 1111.
- Loads: select byte/half lane by the latched ADDR[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Latency with immediate GNT/RVALID:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE).
- Inputs are required stable while OUT_STALL=1; the unit uses only latched copies after IDLE.

Decomposition:
- Package mem_access_pkg holds:
  - size codes SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101;
  - state encoding S_IDLE, S_REQ, S_WAIT, S_DONE;
  - a default for TIMEOUT_CYCLES.
- One combinational sub-module, load_align: inputs rdata, offset[1:0] and size code; output the 32-bit extended result.
- Store lane/strobe generation stays inline.

Test Plan:
- SW 0xDEADBEEF to 0x100, GNT held 1 -> MEM_REQ high 1 cycle, ADDR 0x100, WSTRB 1111, WDATA 0xDEADBEEF; OUT_STALL high 2 cycles; no OUT_LOAD_VALID.
- SB 0x000000A5 to 0x101 -> WSTRB 0010, WDATA 0xA5A5A5A5.
- LB from 0x103, GNT 2 cycles late, RDATA 0x80123456 -> OUT_LOAD_DATA 0xFFFFFF80 with OUT_LOAD_VALID for 1 cycle. LHU from 0x102, same RDATA -> 0x00008012.
- LW from 0x102 -> OUT_MISALIGNED 1 cycle, MEM_REQ never asserted, OUT_STALL 0. Same for illegal code 4'b0011.
- Load with TIMEOUT_CYCLES=4 and no RVALID -> abort after 4 cycles in REQ+WAIT; OUT_BUS_ERR=1, OUT_LOAD_DATA=0, OUT_LOAD_VALID=0; back to IDLE.
- RST_N low during WAIT, then RVALID arrives -> all outputs 0, state IDLE, RVALID ignored, no OUT_LOAD_VALID.
